// File: rtl/runtime_ctr_bank.sv
// Multi-channel runtime counter bank: each channel times start-to-stop (or host synch)
// and holds the result for a registered, select-based readout.
module runtime_ctr_bank #(
    parameter int CTR_WIDTH = 32,
    parameter int NUM_CH    = 4,
    parameter int SAT_MODE  = 0,
    parameter int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    start,
    input  logic [NUM_CH-1:0]    stop,
    input  logic                 synch,
    input  logic                 clear,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic [CTR_WIDTH-1:0] rd_val,
    output logic                 rd_ovf,
    output logic [NUM_CH-1:0]    running,
    output logic [NUM_CH-1:0]    ovf,
    output logic [2*NUM_CH-1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } ch_state_e;

    localparam logic [CTR_WIDTH-1:0] CNT_MAX = '1;

    ch_state_e            state_q [NUM_CH];
    ch_state_e            state_d [NUM_CH];
    logic [CTR_WIDTH-1:0] cnt_q   [NUM_CH];
    logic [CTR_WIDTH-1:0] cnt_d   [NUM_CH];
    logic [NUM_CH-1:0]    ovf_q;
    logic [NUM_CH-1:0]    ovf_d;
    logic [CTR_WIDTH-1:0] sel_val;
    logic                 sel_ovf;

    // State register: channel FSMs together with their counts and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    // Next-state logic. Clear beats everything; in RUN a stop/synch beats a restart.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (clear) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
                ovf_d[i]   = 1'b0;
            end else begin
                case (state_q[i])
                    ST_IDLE, ST_HOLD: begin
                        if (start[i]) begin
                            state_d[i] = ST_RUN;
                            cnt_d[i]   = '0;
                            ovf_d[i]   = 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (stop[i] || synch) begin
                            state_d[i] = ST_HOLD;
                        end else if (start[i]) begin
                            cnt_d[i] = '0;
                            ovf_d[i] = 1'b0;
                        end else if (cnt_q[i] == CNT_MAX) begin
                            cnt_d[i] = (SAT_MODE != 0) ? CNT_MAX : '0;
                            ovf_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Outputs decoded straight from the state register.
    always_comb begin
        running   = '0;
        state_dbg = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            running[i]          = (state_q[i] == ST_RUN);
            state_dbg[2*i +: 2] = state_q[i];
        end
    end

    assign ovf = ovf_q;

    // Unmatched selects (rd_sel >= NUM_CH) fall through to zero.
    always_comb begin
        sel_val = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_val = cnt_q[i];
                sel_ovf = ovf_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_val <= '0;
            rd_ovf <= 1'b0;
        end else begin
            rd_val <= sel_val;
            rd_ovf <= sel_ovf;
        end
    end

endmodule

// File: tb/tb_runtime_ctr_bank.sv
// Directed bench for runtime_ctr_bank: four instances (32b/4ch wrap, 8b wrap, 8b saturate,
// 32b/3ch) share one set of inputs so each scenario exercises every configuration.
module tb_runtime_ctr_bank;

    logic        clk;
    logic        rst;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic        synch;
    logic        clear;
    logic [1:0]  rd_sel;

    logic [31:0] rd_val_a;
    logic        rd_ovf_a;
    logic [3:0]  running_a, ovf_a;
    logic [7:0]  state_a;

    logic [7:0]  rd_val_w;
    logic        rd_ovf_w;
    logic [3:0]  running_w, ovf_w;
    logic [7:0]  state_w;

    logic [7:0]  rd_val_s;
    logic        rd_ovf_s;
    logic [3:0]  running_s, ovf_s;
    logic [7:0]  state_s;

    logic [31:0] rd_val_t;
    logic        rd_ovf_t;
    logic [2:0]  running_t, ovf_t;
    logic [5:0]  state_t;

    int total;
    int bad;

    runtime_ctr_bank #(.CTR_WIDTH(32), .NUM_CH(4), .SAT_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .synch(synch), .clear(clear),
        .rd_sel(rd_sel), .rd_val(rd_val_a), .rd_ovf(rd_ovf_a), .running(running_a),
        .ovf(ovf_a), .state_dbg(state_a));

    runtime_ctr_bank #(.CTR_WIDTH(8), .NUM_CH(4), .SAT_MODE(0)) dut_w (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .synch(synch), .clear(clear),
        .rd_sel(rd_sel), .rd_val(rd_val_w), .rd_ovf(rd_ovf_w), .running(running_w),
        .ovf(ovf_w), .state_dbg(state_w));

    runtime_ctr_bank #(.CTR_WIDTH(8), .NUM_CH(4), .SAT_MODE(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .synch(synch), .clear(clear),
        .rd_sel(rd_sel), .rd_val(rd_val_s), .rd_ovf(rd_ovf_s), .running(running_s),
        .ovf(ovf_s), .state_dbg(state_s));

    runtime_ctr_bank #(.CTR_WIDTH(32), .NUM_CH(3), .SAT_MODE(0)) dut_t (
        .clk(clk), .rst(rst), .start(start[2:0]), .stop(stop[2:0]), .synch(synch),
        .clear(clear), .rd_sel(rd_sel), .rd_val(rd_val_t), .rd_ovf(rd_ovf_t),
        .running(running_t), .ovf(ovf_t), .state_dbg(state_t));

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = '0; stop = '0; synch = 1'b0; clear = 1'b0; rd_sel = '0;
        step(2);
        total++;
        if (rd_val_a !== 32'd0 || rd_ovf_a !== 1'b0) begin
            bad++; $display("FAIL reset_rd: got val=%0d ovf=%0b want 0/0", rd_val_a, rd_ovf_a);
        end
        total++;
        if (running_a !== 4'b0 || ovf_a !== 4'b0 || state_a !== 8'h00) begin
            bad++; $display("FAIL reset_state: got run=%b ovf=%b st=%h want 0", running_a, ovf_a, state_a);
        end
        rst = 1'b1;
        step(3);
        total++;
        if (running_a !== 4'b0 || rd_val_a !== 32'd0) begin
            bad++; $display("FAIL post_reset_idle: got run=%b val=%0d want 0/0", running_a, rd_val_a);
        end
    endtask

    task automatic test_basic_count();
        start = 4'b0001;
        step(1);
        start = '0;
        total++;
        if (running_a !== 4'b0001 || state_a[1:0] !== 2'd1) begin
            bad++; $display("FAIL basic_run: got run=%b st=%0d want 0001/1", running_a, state_a[1:0]);
        end
        step(32);
        total++;
        if (rd_val_a !== 32'd31) begin
            bad++; $display("FAIL basic_first_run: got %0d want 31", rd_val_a);
        end
        start = 4'b0001;
        step(1);
        start = '0;
        step(1);
        total++;
        if (rd_val_a !== 32'd0) begin
            bad++; $display("FAIL basic_restart: got %0d want 0", rd_val_a);
        end
        step(31);
        synch = 1'b1;
        step(1);
        synch = 1'b0;
        total++;
        if (running_a !== 4'b0000 || state_a[1:0] !== 2'd2) begin
            bad++; $display("FAIL basic_synch: got run=%b st=%0d want 0000/2", running_a, state_a[1:0]);
        end
        step(1);
        total++;
        if (rd_val_a !== 32'd32) begin
            bad++; $display("FAIL basic_hold: got %0d want 32", rd_val_a);
        end
        step(5);
        total++;
        if (rd_val_a !== 32'd32 || running_a !== 4'b0) begin
            bad++; $display("FAIL basic_hold_later: got val=%0d run=%b want 32/0000", rd_val_a, running_a);
        end
    endtask

    task automatic test_independent();
        pulse_clear();
        for (int k = 0; k <= 30; k++) begin
            start = (k == 0) ? 4'b0010 : (k == 10) ? 4'b0100 : 4'b0000;
            stop  = (k == 20) ? 4'b0010 : 4'b0000;
            synch = (k == 30);
            step(1);
            if (k == 25) begin
                total++;
                if (running_a !== 4'b0100) begin
                    bad++; $display("FAIL indep_mid_running: got %b want 0100", running_a);
                end
            end
        end
        start = '0; stop = '0; synch = 1'b0;
        total++;
        if (running_a !== 4'b0000) begin
            bad++; $display("FAIL indep_all_held: got %b want 0000", running_a);
        end
        rd_sel = 2'd1;
        step(1);
        rd_sel = 2'd2;
        total++;
        if (rd_val_a !== 32'd19) begin
            bad++; $display("FAIL indep_ch1: got %0d want 19", rd_val_a);
        end
        step(1);
        rd_sel = 2'd0;
        total++;
        if (rd_val_a !== 32'd19) begin
            bad++; $display("FAIL indep_ch2: got %0d want 19", rd_val_a);
        end
        step(1);
        rd_sel = 2'd3;
        total++;
        if (rd_val_a !== 32'd0) begin
            bad++; $display("FAIL indep_ch0: got %0d want 0", rd_val_a);
        end
        step(1);
        rd_sel = 2'd0;
        total++;
        if (rd_val_a !== 32'd0) begin
            bad++; $display("FAIL indep_ch3: got %0d want 0", rd_val_a);
        end
    endtask

    task automatic test_overflow();
        pulse_clear();
        rd_sel = 2'd0;
        start = 4'b0001;
        step(1);
        start = '0;
        step(259);
        stop = 4'b0001;
        step(1);
        stop = '0;
        step(1);
        total++;
        if (rd_val_w !== 8'd3 || rd_ovf_w !== 1'b1 || ovf_w !== 4'b0001) begin
            bad++; $display("FAIL wrap_value: got val=%0d rovf=%0b ovf=%b want 3/1/0001", rd_val_w, rd_ovf_w, ovf_w);
        end
        total++;
        if (rd_val_s !== 8'd255 || rd_ovf_s !== 1'b1 || ovf_s !== 4'b0001) begin
            bad++; $display("FAIL sat_value: got val=%0d rovf=%0b ovf=%b want 255/1/0001", rd_val_s, rd_ovf_s, ovf_s);
        end
        total++;
        if (rd_val_a !== 32'd259 || ovf_a !== 4'b0000) begin
            bad++; $display("FAIL wide_no_ovf: got val=%0d ovf=%b want 259/0000", rd_val_a, ovf_a);
        end
        start = 4'b0001;
        step(1);
        start = '0;
        total++;
        if (ovf_w !== 4'b0000 || ovf_s !== 4'b0000 || running_w !== 4'b0001) begin
            bad++; $display("FAIL ovf_cleared_by_start: got w=%b s=%b run=%b want 0000/0000/0001", ovf_w, ovf_s, running_w);
        end
        step(1);
        total++;
        if (rd_ovf_w !== 1'b0 || rd_val_w !== 8'd0) begin
            bad++; $display("FAIL ovf_readout_cleared: got rovf=%0b val=%0d want 0/0", rd_ovf_w, rd_val_w);
        end
        stop = 4'b0001;
        step(1);
        stop = '0;
    endtask

    task automatic test_simultaneous();
        pulse_clear();
        start = 4'b0011;
        step(1);
        start = '0;
        step(4);
        stop = 4'b0010;
        step(1);
        start = 4'b0001; stop = 4'b0001;
        step(1);
        start = '0; stop = '0;
        total++;
        if (running_a !== 4'b0000 || state_a[3:0] !== 4'b1010) begin
            bad++; $display("FAIL stop_beats_start: got run=%b st=%b want 0000/1010", running_a, state_a[3:0]);
        end
        start = 4'b0010; synch = 1'b1;
        step(1);
        start = '0; synch = 1'b0;
        total++;
        if (running_a !== 4'b0010) begin
            bad++; $display("FAIL start_in_hold_with_synch: got run=%b want 0010", running_a);
        end
        rd_sel = 2'd1;
        step(1);
        rd_sel = 2'd0;
        total++;
        if (rd_val_a !== 32'd0) begin
            bad++; $display("FAIL ch1_restart_value: got %0d want 0", rd_val_a);
        end
        step(1);
        total++;
        if (rd_val_a !== 32'd5) begin
            bad++; $display("FAIL ch0_frozen: got %0d want 5", rd_val_a);
        end
        clear = 1'b1; start = 4'b0100;
        step(1);
        clear = 1'b0; start = '0;
        total++;
        if (running_a !== 4'b0000 || state_a !== 8'h00) begin
            bad++; $display("FAIL clear_wins: got run=%b st=%h want 0000/00", running_a, state_a);
        end
        rd_sel = 2'd1;
        step(1);
        total++;
        if (rd_val_a !== 32'd0) begin
            bad++; $display("FAIL clear_zeroes_count: got %0d want 0", rd_val_a);
        end
    endtask

    task automatic test_async_reset_and_select();
        pulse_clear();
        start = 4'b1111;
        step(1);
        start = '0;
        step(5);
        rd_sel = 2'd3;
        step(1);
        total++;
        if (rd_val_a !== 32'd5) begin
            bad++; $display("FAIL sel3_on_4ch: got %0d want 5", rd_val_a);
        end
        total++;
        if (rd_val_t !== 32'd0 || rd_ovf_t !== 1'b0) begin
            bad++; $display("FAIL sel_out_of_range: got val=%0d ovf=%0b want 0/0", rd_val_t, rd_ovf_t);
        end
        rd_sel = 2'd2;
        step(1);
        total++;
        if (rd_val_t !== 32'd6) begin
            bad++; $display("FAIL sel2_on_3ch: got %0d want 6", rd_val_t);
        end
        rd_sel = 2'd3;
        step(10);
        total++;
        if (rd_val_a !== 32'd16 || running_a !== 4'b1111) begin
            bad++; $display("FAIL pre_reset_count: got val=%0d run=%b want 16/1111", rd_val_a, running_a);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (running_a !== 4'b0 || ovf_a !== 4'b0 || rd_val_a !== 32'd0 || running_t !== 3'b0) begin
            bad++; $display("FAIL async_reset: got run=%b ovf=%b val=%0d run3=%b want all 0",
                            running_a, ovf_a, rd_val_a, running_t);
        end
        step(1);
        rst = 1'b1;
        step(3);
        total++;
        if (running_a !== 4'b0 || rd_val_a !== 32'd0 || state_a !== 8'h00) begin
            bad++; $display("FAIL post_async_idle: got run=%b val=%0d st=%h want 0", running_a, rd_val_a, state_a);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_count();
        test_independent();
        test_overflow();
        test_simultaneous();
        test_async_reset_and_select();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/runtime_ctr_bank.md
Name: runtime_ctr_bank

Overview:
- Parametrised multi-channel successor to the TPU runtime counter.
- Each channel measures the cycles from its own start pulse to its own stop pulse, or to a global host synch. The value is then held for readout.
- Adds per-channel overflow flags, a wrap/saturate mode, a global clear, and a registered select-based readout port.
- Sits beside the control coordinator. Start pulses come from the instruction enables of each unit; synch comes from the host-synchronisation instruction.

Parameters:
- CTR_WIDTH, 32, counter width in bits. Must be ≥ 2.
- NUM_CH, 4, number of independent channels. Must be ≥ 1.
- SAT_MODE, 0, overflow mode. 0 = wrap to 0; 1 = saturate at all-ones.
- SEL_W, $clog2(NUM_CH) (1 when NUM_CH=1), width of rd_sel.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  NUM_CH  per-channel start pulse; bit i drives channel i.
- stop  in  NUM_CH  per-channel stop pulse.
- synch  in  1  global stop pulse to all running channels.
- clear  in  1  synchronous global clear.
- rd_sel  in  SEL_W  channel index for readout.
- rd_val  out  CTR_WIDTH  registered count of the selected channel.
- rd_ovf  out  1  registered overflow flag of the selected channel.
- running  out  NUM_CH  bit i = channel i is in RUN.
- ovf  out  NUM_CH  sticky overflow flag per channel.

Behaviour:
- Reset (rst=0, asynchronous): every channel goes to IDLE. All counts = 0, ovf = 0, running = 0, rd_val = 0, rd_ovf = 0.
- Per-channel states:
  - IDLE: cnt = 0.
  - RUN: counting.
  - HOLD: stopped, value frozen.
- All transitions occur on the rising clk edge.
- clear=1 has highest priority. Next cycle, every channel is in IDLE with cnt = 0 and ovf = 0, regardless of other inputs.
- IDLE or HOLD, start[i]=1: next state RUN, cnt <= 0, ovf[i] <= 0. stop[i] and synch are ignored in that cycle.
- IDLE or HOLD, no start[i]: state and cnt unchanged.
- RUN, stop[i]=1 or synch=1: next state HOLD, cnt unchanged; the stop cycle is not counted. Stop/synch has priority over a simultaneous start[i].
- RUN, start[i] only: restart with cnt <= 0 and ovf[i] <= 0; state stays RUN.
- RUN, no event: cnt increments by 1.
  - Count sequence: start sampled at edge E, then cnt = 0 after E, 1 after E+1, and so on.
  - A stop sampled at edge E+N leaves cnt = N-1 in HOLD.
- Overflow in RUN when cnt = all-ones and incrementing:
  - SAT_MODE=0: cnt <= 0, ovf[i] <= 1.
  - SAT_MODE=1: cnt stays all-ones, ovf[i] <= 1.
  - ovf[i] stays set until start[i], clear, or reset.
- running[i] is combinational from the state register: 1 exactly when the state is RUN.
- Readout has 1-cycle latency.
  - Edge E: rd_val <= cnt[rd_sel] and rd_ovf <= ovf[rd_sel], using the values held before E's update.
  - rd_sel ≥ NUM_CH: rd_val <= 0, rd_ovf <= 0.
- Channels are fully independent apart from synch and clear.
- Reset asserted mid-RUN: immediate IDLE and all outputs 0. After release, nothing counts until the next start.

Test Plan:
1. Reset and basic count (CTR_WIDTH=32, NUM_CH=4).
   - Stimulus: rst low 2 cycles, then high. start[0] pulse 1 cycle. 32 idle cycles. start[0] pulse again. 32 cycles. synch pulse.
   - Response: running[0]=1 after first start; second start restarts from 0. After synch, running=0000 and rd_sel=0 gives rd_val=32 one cycle later. Value stays 32 for ≥5 more cycles.
2. Independent channels.
   - Stimulus: start[1] at cycle 0, start[2] at cycle 10, stop[1] at cycle 20, synch at cycle 30.
   - Response: ch1 holds 19, ch2 holds 19, ch0/ch3 stay 0. Reading rd_sel=1 then rd_sel=2 in consecutive cycles returns 19 then 19, each 1 cycle late.
3. Wrap mode (CTR_WIDTH=8, SAT_MODE=0).
   - Stimulus: start[0], run 260 cycles, stop[0].
   - Response: cnt=3 (259 mod 256), ovf[0]=1, rd_ovf=1. A subsequent start[0] clears ovf[0] to 0.
4. Saturate mode (CTR_WIDTH=8, SAT_MODE=1).
   - Stimulus: same as scenario 3.
   - Response: cnt=255, ovf[0]=1.
5. Simultaneous events.
   - Stimulus: start[0]&stop[0] while in RUN; start[1]&synch while ch1 is in HOLD; clear together with start[2].
   - Response: ch0 goes to HOLD with value frozen. ch1 goes to RUN with cnt=0. All channels go to IDLE with cnt=0 (clear wins).
6. Async reset mid-run and out-of-range select.
   - Stimulus: rst low between clock edges while ch3 is counting (e.g. at count 17).
   - Response: running, ovf, rd_val = 0 immediately, without waiting for a clock edge. With NUM_CH=3, rd_sel=3 gives rd_val=0 and rd_ovf=0.
